pattern_generator: RTL and testbench
====================================

PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, 16, Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, 16, Wishbone data width (one RGB565 pixel).
REQ-003 SHALL have parameter FB_WIDTH, 20, pixels per row; FB_HEIGHT, 15, rows.
REQ-004 SHALL have parameter FRAME_BASE, 0, byte address of page 0; PAGE_STRIDE, 'h0400, page 1 offset; ROW_STRIDE, 64, bytes per row.
REQ-005 SHALL have parameter CTRL_ADDR, 0, matrix display-address register; FRAME_TIME, 2400000, clocks per frame; MAX_WAIT, 8, ack timeout in clocks.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset. Reset rst, asynchronous, active-high; clock clk.
REQ-007 SHALL have ports: adr_o out ADDRESS_WIDTH; dat_i in DATA_WIDTH (unused); dat_o out DATA_WIDTH; we_o out 1; sel_o out DATA_WIDTH/8; stb_o out 1; cyc_o out 1; ack_i in 1; cti_o out 3.
REQ-008 SHALL have ports: enable_i in 1 run enable; mode_i in 2 pattern select; colour_i in 16 user colour; busy_o out 1 frame in progress; overrun_o out 1 sticky missed trigger; err_cnt_o out 8 timeout count.

Function
REQ-009 Frame timer SHALL count down from FRAME_TIME-1 and pulse trigger one cycle on reaching 0, then reload; first trigger 100 cycles after reset.
REQ-010 FSM states SHALL be IDLE, PIXEL, ACK, FLIP, FLIP_ACK; IDLE->PIXEL on trigger with enable_i=1, sampling mode_i and colour_i for the whole frame.
REQ-011 PIXEL SHALL compute address FRAME_BASE + page*PAGE_STRIDE + y*ROW_STRIDE + 2*x and colour, assert cyc_o/stb_o/we_o in the next cycle (ACK); first stb_o one cycle after trigger.
REQ-012 ACK SHALL hold adr_o/dat_o stable until ack_i; on ack_i deassert cyc_o/stb_o next cycle and advance x (then y at x=FB_WIDTH-1, x wraps to 0).
REQ-013 ACK with no ack_i for MAX_WAIT cycles SHALL deassert cyc_o/stb_o, saturating-increment err_cnt_o, and retry the same pixel.
REQ-014 After pixel (FB_WIDTH-1, FB_HEIGHT-1) acks, FLIP SHALL write FRAME_BASE + page*PAGE_STRIDE to CTRL_ADDR; on ack or timeout page toggles, offset += 2 (offset>=22 wraps to 0), go IDLE.
REQ-015 Mode 0 rainbow: idx=(x+y+offset) mod 24, colour by idx/4 = F800, F300, F5E0, 07C0, 001F, 7817.
REQ-016 Mode 1 solid: colour_i; mode 2 checker: colour_i if x[2]^y[2] else 0000; mode 3 gradient: R=x[4:0], G={y[3:0],2'b0}, B=0.
REQ-017 cti_o SHALL be 3'b000, sel_o all ones, we_o=1 whenever cyc_o=1.
REQ-018 Trigger while busy_o=1 SHALL be ignored and set overrun_o until reset.
REQ-019 enable_i deassert mid-frame SHALL complete the frame and flip, then stay IDLE.

Reset
REQ-020 Reset SHALL force IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=0, x=y=0, page=0, offset=0, busy_o=0, overrun_o=0, err_cnt_o=0, timer=100.
REQ-021 Reset mid-transaction SHALL drop cyc_o/stb_o asynchronously.

Configuration
REQ-022 With PATTERN_GEN_MIRROR_EN defined, colour for x>=FB_WIDTH/2 SHALL be computed from FB_WIDTH-1-x (left-right symmetric); undefined, x used directly.

Structure
REQ-023 Shared package SHALL hold FSM state encoding, the six rainbow colour constants, and mode codes.
REQ-024 Colour computation SHALL be sub-module pattern_colour (combinational, inputs mode/x/y/offset/colour; output 16-bit).

Verification
REQ-025 Mode 0, offset 0, ack next cycle: pixel (0,0) addr 0x0000 dat F800; pixel (5,0) addr 0x000A dat F300; 300 writes then CTRL_ADDR write 0x0000.
REQ-026 Second frame: pixel writes at base 0x0400, offset 2 so (0,0)=F800, (2,0)=F300; flip writes 0x0400.
REQ-027 Withhold ack for 8 cycles on pixel (3,1): cyc_o drops, err_cnt_o=1, same address 0x0046 reissued.
REQ-028 Mode 2, colour_i=FFFF: (4,0)=FFFF, (0,0)=0000, (4,4)=0000.
REQ-029 FRAME_TIME=50 with slow slave: overrun_o=1, frame still completes with flip.
REQ-030 PATTERN_GEN_MIRROR_EN defined, mode 3: pixel (19,0) dat equals pixel (0,0) dat 0000.

Source files
------------

// File: rtl/pattern_generator_pkg.sv
// Shared definitions for the pattern generator slice.
//   - state_t: frame-writer FSM encoding
//   - MODE_*: pattern select codes seen on mode_i
//   - RAINBOW_*: the six colour bands of the rainbow pattern
//   - COORD_W / OFFSET_W: internal pixel coordinate and colour-offset widths
package pattern_generator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIXEL,
    ST_ACK,
    ST_FLIP,
    ST_FLIP_ACK
  } state_t;

  localparam logic [1:0] MODE_RAINBOW  = 2'd0;
  localparam logic [1:0] MODE_SOLID    = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_GRADIENT = 2'd3;

  localparam logic [15:0] RAINBOW_0 = 16'hF800;
  localparam logic [15:0] RAINBOW_1 = 16'hF300;
  localparam logic [15:0] RAINBOW_2 = 16'hF5E0;
  localparam logic [15:0] RAINBOW_3 = 16'h07C0;
  localparam logic [15:0] RAINBOW_4 = 16'h001F;
  localparam logic [15:0] RAINBOW_5 = 16'h7817;

  localparam int COORD_W        = 8;
  localparam int OFFSET_W       = 5;
  localparam int RAINBOW_PERIOD = 24;
  localparam int RAINBOW_BAND   = 4;
  localparam int OFFSET_STEP    = 2;
  localparam int OFFSET_LAST    = 22;

  // Band 0..5 of the rainbow; anything else cannot occur and maps to black.
  function automatic logic [15:0] rainbow_colour(input logic [2:0] band);
    logic [15:0] c;
    case (band)
      3'd0:    c = RAINBOW_0;
      3'd1:    c = RAINBOW_1;
      3'd2:    c = RAINBOW_2;
      3'd3:    c = RAINBOW_3;
      3'd4:    c = RAINBOW_4;
      3'd5:    c = RAINBOW_5;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pattern_generator_colour.sv
// pattern_colour: purely combinational RGB565 colour for one pixel.
// Ports:
//   mode_i    pattern select (rainbow / solid / checker / gradient)
//   x_i, y_i  pixel coordinates
//   offset_i  rainbow phase offset, advanced once per frame
//   colour_i  user colour for solid and checker modes
//   pixel_o   resulting RGB565 colour
// Build option: PATTERN_GEN_MIRROR_EN makes the right half of each row a
// mirror image of the left half.
module pattern_colour
  import pattern_generator_pkg::*;
#(
  parameter int FB_WIDTH = 20
) (
  input  logic [1:0]          mode_i,
  input  logic [COORD_W-1:0]  x_i,
  input  logic [COORD_W-1:0]  y_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [15:0]         colour_i,
  output logic [15:0]         pixel_o
);

  logic [COORD_W-1:0] x_eff;
  logic [COORD_W-1:0] sum;
  logic [2:0]         band;

  always_comb begin
    x_eff = x_i;
`ifdef PATTERN_GEN_MIRROR_EN
    if (x_i >= COORD_W'(FB_WIDTH / 2)) begin
      x_eff = COORD_W'(FB_WIDTH - 1) - x_i;
    end
`endif
    sum  = x_eff + y_i + COORD_W'(offset_i);
    band = 3'((sum % COORD_W'(RAINBOW_PERIOD)) / COORD_W'(RAINBOW_BAND));

    case (mode_i)
      MODE_RAINBOW:  pixel_o = rainbow_colour(band);
      MODE_SOLID:    pixel_o = colour_i;
      MODE_CHECKER:  pixel_o = (x_eff[2] ^ y_i[2]) ? colour_i : 16'h0000;
      MODE_GRADIENT: pixel_o = {x_eff[4:0], y_i[3:0], 2'b00, 5'b00000};
      default:       pixel_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/pattern_generator.sv
// pattern_generator: Wishbone master that paints a test pattern into a
// double-buffered frame buffer once per frame period, then writes the base
// of the freshly drawn page to the display-address register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   adr_o/dat_o/we_o/sel_o/stb_o/cyc_o/cti_o, ack_i, dat_i   Wishbone master
//   enable_i                 start a new frame on each frame tick
//   mode_i, colour_i         pattern select and user colour, latched per frame
//   busy_o                   a frame is being written
//   overrun_o                sticky: a frame tick arrived while still busy
//   err_cnt_o                saturating count of ack timeouts
// Build option: PATTERN_GEN_MIRROR_EN (see pattern_colour).
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int FB_WIDTH      = 20,
  parameter int FB_HEIGHT     = 15,
  parameter int FRAME_BASE    = 0,
  parameter int PAGE_STRIDE   = 'h0400,
  parameter int ROW_STRIDE    = 64,
  parameter int CTRL_ADDR     = 0,
  parameter int FRAME_TIME    = 2400000,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic                     we_o,
  output logic [DATA_WIDTH/8-1:0]  sel_o,
  output logic                     stb_o,
  output logic                     cyc_o,
  input  logic                     ack_i,
  output logic [2:0]               cti_o,
  input  logic                     enable_i,
  input  logic [1:0]               mode_i,
  input  logic [15:0]              colour_i,
  output logic                     busy_o,
  output logic                     overrun_o,
  output logic [7:0]               err_cnt_o
);

  localparam int SEL_W      = DATA_WIDTH / 8;
  localparam int FIRST_TICK = 100;
  localparam int TIMER_MAX  = (FRAME_TIME - 1 > FIRST_TICK) ? FRAME_TIME - 1 : FIRST_TICK;
  localparam int TIMER_W    = $clog2(TIMER_MAX + 1);
  localparam int WAIT_W     = $clog2(MAX_WAIT + 1);

  state_t                state_q, state_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
  logic                  page_q, page_d;
  logic [OFFSET_W-1:0]   offset_q, offset_d;
  logic [1:0]            mode_q, mode_d;
  logic [15:0]           colour_q, colour_d;
  logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [7:0]            err_q, err_d;
  logic                  overrun_q, overrun_d;

  logic        trigger;
  logic        last_pixel;
  logic        timeout;
  logic [15:0] pixel_colour;
  logic        unused_dat_i;

  // Read data is never consumed: this master only writes.
  assign unused_dat_i = ^dat_i;

  assign trigger    = (timer_q == '0);
  assign last_pixel = (x_q == COORD_W'(FB_WIDTH - 1)) && (y_q == COORD_W'(FB_HEIGHT - 1));
  // Fires on the last waiting cycle only if the slave still has not answered.
  assign timeout    = (wait_q == WAIT_W'(MAX_WAIT - 1)) && !ack_i;

  pattern_colour #(
    .FB_WIDTH (FB_WIDTH)
  ) u_colour (
    .mode_i   (mode_q),
    .x_i      (x_q),
    .y_i      (y_q),
    .offset_i (offset_q),
    .colour_i (colour_q),
    .pixel_o  (pixel_colour)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= TIMER_W'(FIRST_TICK);
      x_q       <= '0;
      y_q       <= '0;
      page_q    <= 1'b0;
      offset_q  <= '0;
      mode_q    <= MODE_RAINBOW;
      colour_q  <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wait_q    <= '0;
      err_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      x_q       <= x_d;
      y_q       <= y_d;
      page_q    <= page_d;
      offset_q  <= offset_d;
      mode_q    <= mode_d;
      colour_q  <= colour_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (trigger && enable_i) state_d = ST_PIXEL;
      ST_PIXEL:    state_d = ST_ACK;
      ST_ACK: begin
        if (ack_i)        state_d = last_pixel ? ST_FLIP : ST_PIXEL;
        else if (timeout) state_d = ST_PIXEL;
      end
      ST_FLIP:     state_d = ST_FLIP_ACK;
      ST_FLIP_ACK: if (ack_i || timeout) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Datapath: frame timer, pixel walk, bus address/data registers, counters.
  always_comb begin
    timer_d   = trigger ? TIMER_W'(FRAME_TIME - 1) : timer_q - TIMER_W'(1);
    x_d       = x_q;
    y_d       = y_q;
    page_d    = page_q;
    offset_d  = offset_q;
    mode_d    = mode_q;
    colour_d  = colour_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wait_d    = wait_q;
    err_d     = err_q;
    overrun_d = overrun_q;

    if (trigger && state_q != ST_IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (trigger && enable_i) begin
          mode_d   = mode_i;
          colour_d = colour_i;
        end
      end
      ST_PIXEL: begin
        adr_d = ADDRESS_WIDTH'(FRAME_BASE)
              + (page_q ? ADDRESS_WIDTH'(PAGE_STRIDE) : '0)
              + ADDRESS_WIDTH'(y_q) * ADDRESS_WIDTH'(ROW_STRIDE)
              + (ADDRESS_WIDTH'(x_q) << 1);
        dat_d = DATA_WIDTH'(pixel_colour);
      end
      ST_ACK: begin
        if (ack_i) begin
          wait_d = '0;
          if (x_q == COORD_W'(FB_WIDTH - 1)) begin
            x_d = '0;
            y_d = (y_q == COORD_W'(FB_HEIGHT - 1)) ? '0 : y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end else if (timeout) begin
          wait_d = '0;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FLIP: begin
        adr_d = ADDRESS_WIDTH'(CTRL_ADDR);
        dat_d = DATA_WIDTH'(FRAME_BASE) + (page_q ? DATA_WIDTH'(PAGE_STRIDE) : '0);
      end
      ST_FLIP_ACK: begin
        if (ack_i || timeout) begin
          wait_d   = '0;
          page_d   = ~page_q;
          offset_d = (offset_q >= OFFSET_W'(OFFSET_LAST)) ? '0
                   : offset_q + OFFSET_W'(OFFSET_STEP);
          if (timeout && err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Bus strobes come straight from the state register so that reset
  // removes them without waiting for a clock edge.
  always_comb begin
    cyc_o  = (state_q == ST_ACK) || (state_q == ST_FLIP_ACK);
    stb_o  = cyc_o;
    we_o   = cyc_o;
    busy_o = (state_q != ST_IDLE);
  end

  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign sel_o     = {SEL_W{1'b1}};
  assign cti_o     = 3'b000;
  assign overrun_o = overrun_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator. Two instances share clock and reset:
// u_dut1 (FRAME_TIME 700, fast slave) walks four frames covering rainbow,
// checker and gradient modes, an ack timeout and a mid-frame enable drop;
// u_dut2 (FRAME_TIME 50, slow slave) exercises overrun and async reset.
module tb_pattern_generator;

  logic        clk;
  logic        rst;

  logic [15:0] adr1, dat1, adr2, dat2;
  logic [1:0]  sel1, sel2;
  logic [2:0]  cti1, cti2;
  logic        we1, stb1, cyc1, ack1, busy1, overrun1;
  logic        we2, stb2, cyc2, ack2, busy2, overrun2;
  logic [7:0]  err1, err2;
  logic        enable1, enable2;
  logic [1:0]  mode1, mode2;
  logic [15:0] colour1, colour2;
  logic        drop_arm;

  logic [15:0] acc_adr1[$];
  logic [15:0] acc_dat1[$];
  logic [15:0] iss_adr1[$];
  logic [15:0] acc_adr2[$];
  logic [15:0] acc_dat2[$];

  int checks;
  int failures;

`ifdef PATTERN_GEN_MIRROR_EN
  localparam logic [15:0] EXP_F1_X12   = 16'hF300;
  localparam logic [15:0] EXP_F1_X19Y3 = 16'hF800;
  localparam logic [15:0] EXP_F2_LAST  = 16'h001F;
  localparam logic [15:0] EXP_F4_X19   = 16'h0000;
`else
  localparam logic [15:0] EXP_F1_X12   = 16'h07C0;
  localparam logic [15:0] EXP_F1_X19Y3 = 16'h7817;
  localparam logic [15:0] EXP_F2_LAST  = 16'hF5E0;
  localparam logic [15:0] EXP_F4_X19   = 16'h9800;
`endif

  pattern_generator #(
    .FRAME_TIME (700)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .adr_o     (adr1),
    .dat_i     (16'h0000),
    .dat_o     (dat1),
    .we_o      (we1),
    .sel_o     (sel1),
    .stb_o     (stb1),
    .cyc_o     (cyc1),
    .ack_i     (ack1),
    .cti_o     (cti1),
    .enable_i  (enable1),
    .mode_i    (mode1),
    .colour_i  (colour1),
    .busy_o    (busy1),
    .overrun_o (overrun1),
    .err_cnt_o (err1)
  );

  pattern_generator #(
    .FRAME_TIME (50)
  ) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .adr_o     (adr2),
    .dat_i     (16'h0000),
    .dat_o     (dat2),
    .we_o      (we2),
    .sel_o     (sel2),
    .stb_o     (stb2),
    .cyc_o     (cyc2),
    .ack_i     (ack2),
    .cti_o     (cti2),
    .enable_i  (enable2),
    .mode_i    (mode2),
    .colour_i  (colour2),
    .busy_o    (busy2),
    .overrun_o (overrun2),
    .err_cnt_o (err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave models, evaluated on the falling edge. DUT1 acks in the first
  // strobe cycle except for eight withheld cycles on address 0x0046 once
  // armed; DUT2 acks on the third strobe cycle. Accepted writes and
  // strobe rising edges are logged for the checks below.
  initial begin
    int drop_left;
    int slow_cnt;
    logic stb1_prev;
    drop_left = 8;
    slow_cnt  = 0;
    stb1_prev = 1'b0;
    ack1 = 1'b0;
    ack2 = 1'b0;
    forever begin
      @(negedge clk);
      if (stb1 && !stb1_prev) iss_adr1.push_back(adr1);
      stb1_prev = stb1;
      if (stb1 && !ack1) begin
        if (drop_arm && drop_left > 0 && adr1 == 16'h0046) begin
          drop_left--;
        end else begin
          ack1 = 1'b1;
          acc_adr1.push_back(adr1);
          acc_dat1.push_back(dat1);
        end
      end else begin
        ack1 = 1'b0;
      end

      if (stb2 && !ack2) begin
        if (slow_cnt == 2) begin
          ack2 = 1'b1;
          slow_cnt = 0;
          acc_adr2.push_back(adr2);
          acc_dat2.push_back(dat2);
        end else begin
          slow_cnt++;
        end
      end else begin
        ack2 = 1'b0;
      end
    end
  end

  function automatic logic [15:0] a1(input int i);
    return (i < acc_adr1.size()) ? acc_adr1[i] : 16'hxxxx;
  endfunction
  function automatic logic [15:0] d1(input int i);
    return (i < acc_dat1.size()) ? acc_dat1[i] : 16'hxxxx;
  endfunction
  function automatic logic [15:0] i1(input int i);
    return (i < iss_adr1.size()) ? iss_adr1[i] : 16'hxxxx;
  endfunction
  function automatic logic [15:0] a2(input int i);
    return (i < acc_adr2.size()) ? acc_adr2[i] : 16'hxxxx;
  endfunction
  function automatic logic [15:0] d2(input int i);
    return (i < acc_dat2.size()) ? acc_dat2[i] : 16'hxxxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Wait until the slave of the chosen DUT has accepted n writes.
  task automatic waitWrites(input int which, input int n, input int budget, input string tag);
    int cnt;
    int spent;
    spent = 0;
    cnt = (which == 1) ? acc_adr1.size() : acc_adr2.size();
    while (cnt < n && spent < budget) begin
      @(posedge clk);
      spent++;
      cnt = (which == 1) ? acc_adr1.size() : acc_adr2.size();
    end
    if (cnt < n) checkOutput(tag, cnt, n);
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] mode, input logic [15:0] colour);
    enable1 = en;
    mode1   = mode;
    colour1 = colour;
  endtask

  initial begin
    int spent;
    checks   = 0;
    failures = 0;
    drop_arm = 1'b0;
    rst      = 1'b1;
    applyStimulus(1'b1, 2'd0, 16'h0000);
    enable2  = 1'b1;
    mode2    = 2'd0;
    colour2  = 16'h0000;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_cyc", cyc1, 1'b0);
    checkOutput("rst_stb", stb1, 1'b0);
    checkOutput("rst_we", we1, 1'b0);
    checkOutput("rst_adr", adr1, 16'h0000);
    checkOutput("rst_dat", dat1, 16'h0000);
    checkOutput("rst_busy", busy1, 1'b0);
    checkOutput("rst_overrun", overrun1, 1'b0);
    checkOutput("rst_err", err1, 8'd0);

    // First frame tick 100 cycles after reset.
    repeat (100) @(posedge clk);
    #1 checkOutput("tick_busy_before", busy1, 1'b0);
    @(posedge clk);
    #1 checkOutput("tick_busy_after", busy1, 1'b1);
    @(posedge clk);
    #1 checkOutput("first_stb", stb1, 1'b1);
    checkOutput("first_we", we1, 1'b1);
    checkOutput("first_sel", sel1, 2'b11);
    checkOutput("first_cti", cti1, 3'b000);

    // Frame 1: page 0, rainbow, offset 0.
    waitWrites(1, 301, 1500, "wait_frame1");
    checkOutput("f1_p00_adr", a1(0), 16'h0000);
    checkOutput("f1_p00_dat", d1(0), 16'hF800);
    checkOutput("f1_p50_adr", a1(5), 16'h000A);
    checkOutput("f1_p50_dat", d1(5), 16'hF300);
    checkOutput("f1_p120_dat", d1(12), EXP_F1_X12);
    checkOutput("f1_p193_adr", a1(79), 16'h00E6);
    checkOutput("f1_p193_dat", d1(79), EXP_F1_X19Y3);
    checkOutput("f1_flip_adr", a1(300), 16'h0000);
    checkOutput("f1_flip_dat", d1(300), 16'h0000);

    // Frame 2: page 1, rainbow, offset 2.
    waitWrites(1, 602, 1500, "wait_frame2");
    checkOutput("f2_p00_adr", a1(301), 16'h0400);
    checkOutput("f2_p00_dat", d1(301), 16'hF800);
    checkOutput("f2_p20_adr", a1(303), 16'h0404);
    checkOutput("f2_p20_dat", d1(303), 16'hF300);
    checkOutput("f2_last_adr", a1(600), 16'h07A6);
    checkOutput("f2_last_dat", d1(600), EXP_F2_LAST);
    checkOutput("f2_flip_adr", a1(601), 16'h0000);
    checkOutput("f2_flip_dat", d1(601), 16'h0400);

    // Frame 3: page 0, checker, ack withheld on pixel (3,1).
    applyStimulus(1'b1, 2'd2, 16'hFFFF);
    drop_arm = 1'b1;
    waitWrites(1, 903, 1500, "wait_frame3");
    checkOutput("f3_p40_dat", d1(606), 16'hFFFF);
    checkOutput("f3_p00_dat", d1(602), 16'h0000);
    checkOutput("f3_p44_dat", d1(686), 16'h0000);
    checkOutput("f3_p04_dat", d1(682), 16'hFFFF);
    checkOutput("f3_issue_adr", i1(625), 16'h0046);
    checkOutput("f3_retry_adr", i1(626), 16'h0046);
    checkOutput("f3_next_adr", i1(627), 16'h0048);
    checkOutput("f3_acc_adr", a1(625), 16'h0046);
    checkOutput("f3_err_cnt", err1, 8'd1);
    checkOutput("f3_overrun", overrun1, 1'b0);
    checkOutput("f3_flip_dat", d1(902), 16'h0000);

    // Frame 4: page 1, gradient; enable drops after ten pixels.
    applyStimulus(1'b1, 2'd3, 16'h0000);
    waitWrites(1, 913, 1500, "wait_frame4_start");
    applyStimulus(1'b0, 2'd3, 16'h0000);
    waitWrites(1, 1204, 1500, "wait_frame4");
    checkOutput("f4_p00_dat", d1(903), 16'h0000);
    checkOutput("f4_p190_dat", d1(922), EXP_F4_X19);
    checkOutput("f4_p53_dat", d1(968), 16'h2980);
    checkOutput("f4_p014_dat", d1(1183), 16'h0700);
    checkOutput("f4_flip_adr", a1(1203), 16'h0000);
    checkOutput("f4_flip_dat", d1(1203), 16'h0400);
    repeat (900) @(posedge clk);
    #1 checkOutput("disabled_writes", acc_adr1.size(), 1204);
    checkOutput("disabled_busy", busy1, 1'b0);
    checkOutput("disabled_overrun", overrun1, 1'b0);

    // Short frame period with slow slave: overrun, frame still flips.
    waitWrites(2, 302, 6000, "wait_slow_frame");
    checkOutput("slow_p00_dat", d2(0), 16'hF800);
    checkOutput("slow_flip_adr", a2(300), 16'h0000);
    checkOutput("slow_flip_dat", d2(300), 16'h0000);
    checkOutput("slow_page1_adr", a2(301), 16'h0400);
    checkOutput("slow_overrun", overrun2, 1'b1);

    // Reset in the middle of a bus cycle removes the strobes at once.
    spent = 0;
    while (!stb2 && spent < 100) begin
      @(posedge clk);
      #1;
      spent++;
    end
    checkOutput("midrst_stb_seen", stb2, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cyc", cyc2, 1'b0);
    checkOutput("midrst_stb", stb2, 1'b0);
    checkOutput("midrst_busy", busy2, 1'b0);
    checkOutput("midrst_overrun", overrun2, 1'b0);
    checkOutput("midrst_err1", err1, 8'd0);
    checkOutput("midrst_adr1", adr1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
